// File: rtl/morse_decoder_pkg.sv
// Shared Morse receive definitions: letter codes, FSM states, and the dot/dash pattern of each letter.
// Patterns are {sym_cnt, sym_bits}; dash = 1, the first symbol ends up in the highest used bit.
package morse_decoder_pkg;

  localparam logic [2:0] LTR_I = 3'd0;
  localparam logic [2:0] LTR_J = 3'd1;
  localparam logic [2:0] LTR_K = 3'd2;
  localparam logic [2:0] LTR_L = 3'd3;
  localparam logic [2:0] LTR_M = 3'd4;
  localparam logic [2:0] LTR_N = 3'd5;
  localparam logic [2:0] LTR_O = 3'd6;
  localparam logic [2:0] LTR_P = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MARK  = 3'd1,
    ST_SPACE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [6:0] PAT_I = {3'd2, 4'b0000};  // ..
  localparam logic [6:0] PAT_J = {3'd4, 4'b0111};  // .---
  localparam logic [6:0] PAT_K = {3'd3, 4'b0101};  // -.-
  localparam logic [6:0] PAT_L = {3'd4, 4'b0100};  // .-..
  localparam logic [6:0] PAT_M = {3'd2, 4'b0011};  // --
  localparam logic [6:0] PAT_N = {3'd2, 4'b0010};  // -.
  localparam logic [6:0] PAT_O = {3'd3, 4'b0111};  // ---
  localparam logic [6:0] PAT_P = {3'd4, 4'b0110};  // .--.

  function automatic logic [6:0] sym_pat(input logic [2:0] ltr);
    case (ltr)
      LTR_I:   sym_pat = PAT_I;
      LTR_J:   sym_pat = PAT_J;
      LTR_K:   sym_pat = PAT_K;
      LTR_L:   sym_pat = PAT_L;
      LTR_M:   sym_pat = PAT_M;
      LTR_N:   sym_pat = PAT_N;
      LTR_O:   sym_pat = PAT_O;
      LTR_P:   sym_pat = PAT_P;
      default: sym_pat = '0;
    endcase
  endfunction

endpackage

// File: rtl/morse_decode_lut.sv
// Combinational lookup of a collected symbol sequence against the letter patterns I..P.
module morse_decode_lut
  import morse_decoder_pkg::*;
(
  input  logic [2:0] i_sym_cnt,
  input  logic [3:0] i_sym_bits,
  output logic       o_match,
  output logic [2:0] o_letter
);

  always_comb begin
    o_match  = 1'b0;
    o_letter = LTR_I;
    for (int k = 0; k < 8; k++) begin
      if ({i_sym_cnt, i_sym_bits} == sym_pat(3'(k))) begin
        o_match  = 1'b1;
        o_letter = 3'(k);
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: synchronizes the key line, samples it mid-unit, collects dots/dashes and decodes I..P.
// letter_valid rises 2 clocks after the sample tick that completes the third space unit.
module morse_decoder
  import morse_decoder_pkg::*;
#(
  parameter int RATE_W  = 32,
  parameter int RUN_W   = 3,
  parameter int MAX_SYM = 4
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  input  logic [RATE_W-1:0] i_rate,
  input  logic              i_morse_in,
  output logic [2:0]        o_letter,
  output logic              o_letter_valid,
  output logic              o_error,
  output logic              o_busy
);

  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  logic               r_sync1, r_sync2, r_prev;
  logic [RATE_W-1:0]  r_unit_cnt;
  logic [RUN_W-1:0]   r_mark_run, r_space_run;
  logic [MAX_SYM-1:0] r_sym_bits;
  logic [2:0]         r_sym_cnt;
  state_t             r_state, w_state_nxt;
  logic [2:0]         r_letter;
  logic               r_letter_valid, r_error;

  logic       w_rise, w_fall, w_edge, w_tick, w_space3;
  logic       w_sym_ok, w_dash, w_room, w_shift, w_clr;
  logic       w_match, w_valid_nxt, w_err_nxt;
  logic [2:0] w_lut_letter;

  assign w_rise   = r_sync2 & ~r_prev;
  assign w_fall   = ~r_sync2 & r_prev;
  assign w_edge   = w_rise | w_fall;
  assign w_tick   = ~w_edge & (r_unit_cnt == '0);
  // Third space unit is recognised on the tick itself, not a cycle later from the registered count
  assign w_space3 = (r_space_run >= RUN_W'(3)) |
                    (w_tick & ~r_sync2 & (r_space_run == RUN_W'(2)));
  assign w_sym_ok = (r_mark_run != '0) && (r_mark_run <= RUN_W'(4));
  assign w_dash   = (r_mark_run >= RUN_W'(2));
  assign w_room   = (r_sym_cnt < 3'(MAX_SYM));
  assign w_shift  = (r_state == ST_MARK) && w_fall && w_sym_ok && w_room;
  assign w_clr    = (r_state == ST_DONE) || (r_state == ST_ERR);

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_prev      <= 1'b0;
      r_unit_cnt  <= '0;
      r_mark_run  <= '0;
      r_space_run <= '0;
    end else begin
      r_sync1 <= i_morse_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_edge)                  r_unit_cnt <= i_rate >> 1;
      else if (r_unit_cnt == '0)   r_unit_cnt <= i_rate;
      else                         r_unit_cnt <= r_unit_cnt - RATE_W'(1);
      if (w_fall)
        r_mark_run <= '0;
      else if (w_tick && r_sync2 && (r_mark_run != RUN_MAX))
        r_mark_run <= r_mark_run + RUN_W'(1);
      if (w_rise)
        r_space_run <= '0;
      else if (w_tick && !r_sync2 && (r_space_run != RUN_MAX))
        r_space_run <= r_space_run + RUN_W'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sym_bits <= '0;
      r_sym_cnt  <= '0;
    end else if (w_clr) begin
      r_sym_bits <= '0;
      r_sym_cnt  <= '0;
    end else if (w_shift) begin
      r_sym_bits <= {r_sym_bits[MAX_SYM-2:0], w_dash};
      r_sym_cnt  <= r_sym_cnt + 3'd1;
    end
  end

  morse_decode_lut u_lut (
    .i_sym_cnt  (r_sym_cnt),
    .i_sym_bits (r_sym_bits),
    .o_match    (w_match),
    .o_letter   (w_lut_letter)
  );

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // Level, not edge: a rise landing in the DONE cycle is still picked up one clock later
      ST_IDLE:  if (r_sync2) w_state_nxt = ST_MARK;
      ST_MARK: begin
        if (r_mark_run >= RUN_W'(5))
          w_state_nxt = ST_ERR;
        else if (w_fall)
          w_state_nxt = (w_sym_ok && w_room) ? ST_SPACE : ST_ERR;
      end
      ST_SPACE: begin
        if (w_space3)
          w_state_nxt = ST_DONE;
        else if (w_rise)
          w_state_nxt = (r_space_run != '0) ? ST_MARK : ST_ERR;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_ERR:   if (w_space3) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state != ST_IDLE);
    w_valid_nxt = (r_state == ST_DONE) && w_match;
    w_err_nxt   = ((r_state == ST_DONE) && !w_match) ||
                  ((r_state != ST_ERR) && (w_state_nxt == ST_ERR));
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_letter       <= '0;
      r_letter_valid <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_letter_valid <= w_valid_nxt;
      r_error        <= w_err_nxt;
      if (w_valid_nxt) r_letter <= w_lut_letter;
    end
  end

  assign o_letter       = r_letter;
  assign o_letter_valid = r_letter_valid;
  assign o_error        = r_error;

endmodule
